// File: rtl/uart_pkg.sv
// uart_pkg: shared UART TX encodings, frame constants and MMIO map.
// Imported by the interface, the transmitter and MemOrIO.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    localparam logic [7:0] TX_DATA_OFS = 8'h00;
    localparam logic [7:0] TX_STAT_OFS = 8'h04;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: MemOrIO-side write strobe and status bundle.
// master = MemOrIO, slave = transmitter.
interface uart_tx_mmio_if #(
    parameter int FIFO_DEPTH = 16
);
    import uart_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_ovf;
    logic          tx_busy;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  tx_busy, fifo_full, fifo_empty, fifo_count, overflow
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output tx_busy, fifo_full, fifo_empty, fifo_count, overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two depth.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: MMIO-fed 8N1 UART transmitter, LSB first.
// A byte FIFO decouples CPU writes from the serial line.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 23000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rstn,
    uart_tx_mmio_if.slave bus,
    output logic          tx
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t      state_q, state_n;
    logic [BW-1:0]  cnt_q, cnt_n;
    logic [2:0]     idx_q, idx_n;
    logic [7:0]     shift_q, shift_n;
    logic           tx_n;
    logic           busy_q, busy_n;
    logic           ovf_q;
    logic           pop;
    logic           bit_end;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (bus.wr_en),
        .wr_data (bus.wr_data),
        .pop     (pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_end        = (cnt_q == BAUD_LAST);
    assign bus.fifo_full  = fifo_full;
    assign bus.fifo_empty = fifo_empty;
    assign bus.fifo_count = fifo_count;
    assign bus.tx_busy    = busy_q;
    assign bus.overflow   = ovf_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        shift_n = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                cnt_n = cnt_q + BW'(1);
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                cnt_n = cnt_q + BW'(1);
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = shift_q >> 1;
                    if (idx_q == BIT_LAST) state_n = STOP;
                    else idx_n = idx_q + 3'd1;
                end
            end
            STOP: begin
                cnt_n = cnt_q + BW'(1);
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    // Chain straight into the next frame.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_dout;
                        state_n = START;
                    end
                end
            end
        endcase
        tx_n = 1'b1;
        if (state_n == START)     tx_n = 1'b0;
        else if (state_n == DATA) tx_n = shift_n[0];
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            shift_q <= shift_n;
            tx      <= tx_n;
            busy_q  <= busy_n;
        end
    end

    // A dropped push beats a same-edge clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                        ovf_q <= 1'b0;
        else if (bus.wr_en && fifo_full) ovf_q <= 1'b1;
        else if (bus.clr_ovf)             ovf_q <= 1'b0;
    end

endmodule
